nibble_packer: RTL and testbench

//  Serial-to-parallel assembler: accepts one 4-bit nibble per handshake and builds a
//  16-bit word, slot 0 first. Slot k occupies bits [4k+3:4k], the same slot order used
//  by the 4-bit nibble selector on the display/readout path. A unit that writes nibbles

---
 rtl/pack_pkg.sv | 12 +
 rtl/nibble_demux.sv | 15 +
 rtl/nibble_packer.sv | 83 ++++++++
 tb/tb_nibble_packer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// Shared sizing and state encoding for the nibble packer.
package pack_pkg;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = 4;
    localparam int WORD_W  = NIB_W * NIBBLES;
    localparam int SLOT_W  = $clog2(NIBBLES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;
endpackage

// File: rtl/nibble_demux.sv
// Slot index to one-hot nibble write enable; inverse of the readout nibble selector.
module nibble_demux
    import pack_pkg::*;
(
    input  logic [SLOT_W-1:0]  slot,
    input  logic               accept,
    output logic [NIBBLES-1:0] wr_en
);
    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[slot] = 1'b1;
        end
    end
endmodule

// File: rtl/nibble_packer.sv
// Assembles NIBBLES nibbles (slot 0 first) into one word and holds it until taken.
//
// state | meaning
// FILL  | accepting nibbles into word register, word_valid low
// HOLD  | word complete, inputs ignored until consumer handshake
module nibble_packer
    import pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [NIB_W-1:0]  nib_in,
    input  logic              nib_valid,
    output logic              nib_ready,
    output logic [SLOT_W-1:0] slot,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready
);
    pack_state_t        state_q, state_d;
    logic [SLOT_W-1:0]  slot_q;
    logic [WORD_W-1:0]  word_q;
    logic [NIBBLES-1:0] wr_en;
    logic               accept;
    logic               take;
    logic               last_slot;

    assign accept    = (state_q == FILL) && nib_valid;
    assign take      = (state_q == HOLD) && word_ready;
    assign last_slot = (slot_q == SLOT_W'(NIBBLES - 1));

    nibble_demux u_demux (
        .slot   (slot_q),
        .accept (accept),
        .wr_en  (wr_en)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (accept && last_slot) state_d = HOLD;
                HOLD:    if (take) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear wins over an accept in the same cycle, so the offered nibble is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            word_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
            word_q <= '0;
        end else begin
            if (accept) begin
                slot_q <= slot_q + SLOT_W'(1);
            end
            for (int k = 0; k < NIBBLES; k++) begin
                if (wr_en[k]) begin
                    word_q[k*NIB_W +: NIB_W] <= nib_in;
                end
            end
        end
    end

    assign nib_ready  = (state_q == FILL);
    assign word_valid = (state_q == HOLD);
    assign slot       = slot_q;
    assign word_out   = word_q;
endmodule

// File: tb/tb_nibble_packer.sv
// Directed and randomized checks of nibble_packer against hand-computed words.
module tb_nibble_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic [1:0]  slot;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;

    int n_vec  = 0;
    int n_miss = 0;

    nibble_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .slot       (slot),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] n);
        nib_valid = 1'b1;
        nib_in    = n;
        step();
    endtask

    logic [15:0] words [200];
    logic [15:0] prev_word;
    logic        prev_stall;
    int          ni, wi, ri, cyc;
    logic [15:0] gap_nibs;
    logic [6:0]  gap_pat;
    int          gi, exp_slot;

    initial begin
        rst_n = 1'b0; clear = 1'b0; nib_in = '0; nib_valid = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("por_nib_ready", nib_ready, 1);
        chk("por_word_valid", word_valid, 0);

        // 1: reset mid-word
        feed(4'h3);
        feed(4'h7);
        chk("rst_pre_slot", slot, 2);
        nib_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_word_out", word_out, 16'h0000);
        chk("rst_slot", slot, 0);
        chk("rst_word_valid", word_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_nib_ready", nib_ready, 1);
        chk("rst_slot_after", slot, 0);

        // 2: back-to-back word
        word_ready = 1'b1;
        feed(4'hA);
        feed(4'hB);
        feed(4'hC);
        chk("basic_not_yet_valid", word_valid, 0);
        feed(4'hD);
        nib_valid = 1'b0;
        chk("basic_valid", word_valid, 1);
        chk("basic_word", word_out, 16'hDCBA);
        chk("basic_hold_ready", nib_ready, 0);
        step();
        chk("basic_valid_drop", word_valid, 0);
        chk("basic_nib_ready", nib_ready, 1);
        word_ready = 1'b0;

        // 3: backpressure with junk nibbles offered in HOLD
        feed(4'h1);
        feed(4'h2);
        feed(4'h3);
        feed(4'h4);
        nib_in = 4'hF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_word", word_out, 16'h4321);
            chk("bp_nib_ready", nib_ready, 0);
            step();
        end
        chk("bp_slot", slot, 0);
        word_ready = 1'b1;
        nib_valid  = 1'b0;
        step();
        chk("bp_released", word_valid, 0);
        chk("bp_slot_after", slot, 0);
        chk("bp_word_kept", word_out, 16'h4321);
        word_ready = 1'b0;

        // 4: gaps in nib_valid (pattern applied LSB first)
        gap_pat  = 7'b1101001;
        gap_nibs = 16'h8765;
        gi = 0; exp_slot = 0;
        for (int i = 0; i < 7; i++) begin
            nib_valid = gap_pat[i];
            nib_in    = gap_pat[i] ? gap_nibs[gi*4 +: 4] : 4'h0;
            step();
            if (gap_pat[i]) begin
                gi++;
                exp_slot = (exp_slot + 1) % 4;
            end
            chk("gap_slot", slot, exp_slot);
        end
        nib_valid = 1'b0;
        chk("gap_valid", word_valid, 1);
        chk("gap_word", word_out, 16'h8765);
        word_ready = 1'b1;
        step();
        chk("gap_released", word_valid, 0);
        word_ready = 1'b0;

        // 5: clear mid-word, then clear in HOLD with word_ready high
        feed(4'h9);
        feed(4'hA);
        feed(4'hB);
        clear = 1'b1; nib_in = 4'hC; nib_valid = 1'b1;
        step();
        clear = 1'b0; nib_valid = 1'b0;
        chk("clr_slot", slot, 0);
        chk("clr_word", word_out, 16'h0000);
        chk("clr_nib_ready", nib_ready, 1);
        feed(4'h1);
        feed(4'h2);
        feed(4'h3);
        feed(4'h4);
        nib_valid = 1'b0;
        chk("clr_hold_valid", word_valid, 1);
        clear = 1'b1; word_ready = 1'b1;
        step();
        clear = 1'b0; word_ready = 1'b0;
        chk("clr_hold_valid_drop", word_valid, 0);
        chk("clr_hold_word", word_out, 16'h0000);
        chk("clr_hold_slot", slot, 0);
        step();
        chk("clr_no_revive", word_valid, 0);

        // 6: random traffic against a queue of pre-generated words
        for (int i = 0; i < 200; i++) words[i] = 16'($urandom);
        ni = 0; wi = 0; ri = 0; cyc = 0;
        prev_stall = 1'b0; prev_word = '0;
        while (ri < 200 && cyc < 20000) begin
            if (prev_stall && word_valid)
                chk("rnd_stable", word_out, prev_word);
            nib_valid  = (wi < 200) && ($urandom_range(0, 3) != 0);
            nib_in     = (wi < 200) ? words[wi][ni*4 +: 4] : 4'h0;
            word_ready = ($urandom_range(0, 2) != 0);
            if (word_valid && word_ready) begin
                chk("rnd_word", word_out, words[ri]);
                ri++;
            end
            if (nib_valid && nib_ready) begin
                ni++;
                if (ni == 4) begin ni = 0; wi++; end
            end
            prev_stall = word_valid && !word_ready;
            prev_word  = word_out;
            step();
            cyc++;
        end
        chk("rnd_words_taken", ri, 200);
        nib_valid = 1'b0; word_ready = 1'b0;
        step();
        chk("rnd_no_extra", word_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
